// File: rtl/mips_pipe_pkg.sv
// Shared types and constants for the MIPS pipeline hazard controller.
// Optional stall counter in pipe_hazard_ctrl is enabled with STALL_CNT_EN.
package mips_pipe_pkg;
   typedef enum logic [1:0] {RUN = 2'd0, MD_BUSY = 2'd1, MD_DONE = 2'd2} pipe_state_t;

   typedef struct packed {
      logic pc_en;
      logic ifid_en;
      logic idex_en;
      logic ifid_flush;
      logic idex_flush;
      logic exmem_flush;
      logic md_busy;
      logic md_done;
   } pipe_ctrl_t;

   localparam logic [4:0] REG_ZERO   = 5'd0;
   localparam int         MD_LAT_DEF = 32;
   localparam int         MD_CNT_W   = 7;
endpackage

// File: rtl/md_lat_counter.sv
// Load/decrement down-counter timing the mult/div busy window.
module md_lat_counter #(
   parameter int W = 7
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic         dec,
   input  logic [W-1:0] load_val,
   output logic         zero
);
   logic [W-1:0] cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                   cnt <= '0;
      else if (load)                cnt <= load_val;
      else if (dec && cnt != '0)    cnt <= cnt - W'(1);
   end

   assign zero = (cnt == '0);
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, taken branch, mult/div freeze.
// Define STALL_CNT_EN to build the saturating stall-cycle counter.
module pipe_hazard_ctrl
   import mips_pipe_pkg::*;
#(
   parameter int REG_ADDR_W = 5,
   parameter int MD_LAT     = MD_LAT_DEF,
   parameter int CNT_W      = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic                  id_branch_taken,
   input  logic                  ex_memread,
   input  logic [REG_ADDR_W-1:0] ex_rt,
   input  logic                  ex_md_start,
   output logic                  pc_en,
   output logic                  ifid_en,
   output logic                  ifid_flush,
   output logic                  idex_en,
   output logic                  idex_flush,
   output logic                  exmem_flush,
   output logic                  md_busy,
   output logic                  md_done,
   output logic [CNT_W-1:0]      stall_cycles
);
   pipe_state_t state_q, state_d;
   pipe_ctrl_t  ctrl_raw, ctrl_out;
   logic        live, active, load_use, md_load, md_dec, md_zero;

   // Outputs stay quiet until the first edge after reset release.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) live <= 1'b0;
      else        live <= 1'b1;
   end
   assign active = reset && live;

   assign load_use = ex_memread && (ex_rt != REG_ADDR_W'(REG_ZERO)) &&
                     ((ex_rt == id_rs) || (ex_rt == id_rt));

   md_lat_counter #(.W(MD_CNT_W)) u_md_cnt (
      .clk      (clk),
      .reset    (reset),
      .load     (md_load),
      .dec      (md_dec),
      .load_val (MD_CNT_W'(MD_LAT - 1)),
      .zero     (md_zero)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= RUN;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = RUN;
      md_load = 1'b0;
      md_dec  = 1'b0;
      case (state_q)
         MD_BUSY: begin
            md_dec  = 1'b1;
            state_d = md_zero ? MD_DONE : MD_BUSY;
         end
         MD_DONE: state_d = RUN;
         default: begin
            md_load = ex_md_start;
            state_d = ex_md_start ? MD_BUSY : RUN;
         end
      endcase
   end

   always_comb begin
      ctrl_raw         = '0;
      ctrl_raw.pc_en   = 1'b1;
      ctrl_raw.ifid_en = 1'b1;
      ctrl_raw.idex_en = 1'b1;
      case (state_q)
         MD_BUSY: begin
            ctrl_raw.pc_en       = 1'b0;
            ctrl_raw.ifid_en     = 1'b0;
            ctrl_raw.idex_en     = 1'b0;
            ctrl_raw.exmem_flush = 1'b1;
            ctrl_raw.md_busy     = 1'b1;
         end
         MD_DONE: ctrl_raw.md_done = 1'b1;
         default: begin
            // A mult/div start outranks the load-use stall; a stall defers the branch squash.
            if (load_use && !ex_md_start) begin
               ctrl_raw.pc_en      = 1'b0;
               ctrl_raw.ifid_en    = 1'b0;
               ctrl_raw.idex_flush = 1'b1;
            end else if (id_branch_taken) begin
               ctrl_raw.ifid_flush = 1'b1;
            end
         end
      endcase
   end

   assign ctrl_out    = active ? ctrl_raw : '0;
   assign pc_en       = ctrl_out.pc_en;
   assign ifid_en     = ctrl_out.ifid_en;
   assign ifid_flush  = ctrl_out.ifid_flush;
   assign idex_en     = ctrl_out.idex_en;
   assign idex_flush  = ctrl_out.idex_flush;
   assign exmem_flush = ctrl_out.exmem_flush;
   assign md_busy     = ctrl_out.md_busy;
   assign md_done     = ctrl_out.md_done;

`ifdef STALL_CNT_EN
   logic [CNT_W-1:0] stall_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         stall_q <= '0;
      else if (active && !ctrl_raw.pc_en && stall_q != '1)
         stall_q <= stall_q + CNT_W'(1);
   end
   assign stall_cycles = stall_q;
`else
   assign stall_cycles = '0;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized bench for pipe_hazard_ctrl against a cycle-level behavioural model.
// Stall-count expectations follow STALL_CNT_EN.
module tb_pipe_hazard_ctrl;
   localparam int RW     = 5;
   localparam int MDL    = 4;
   localparam int CW     = 32;
`ifdef STALL_CNT_EN
   localparam logic [31:0] T6_EXP = 32'd5;
`else
   localparam logic [31:0] T6_EXP = 32'd0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic [RW-1:0] id_rs, id_rt, ex_rt;
   logic          id_branch_taken, ex_memread, ex_md_start;
   logic          pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_flush, md_busy, md_done;
   logic [CW-1:0] stall_cycles;

   int vectors = 0;
   int miscompares = 0;

   pipe_hazard_ctrl #(.REG_ADDR_W(RW), .MD_LAT(MDL), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
      .id_branch_taken(id_branch_taken), .ex_memread(ex_memread), .ex_rt(ex_rt),
      .ex_md_start(ex_md_start), .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
      .idex_en(idex_en), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
      .md_busy(md_busy), .md_done(md_done), .stall_cycles(stall_cycles)
   );

   always #5 clk = ~clk;

   // Model: 0 = running, 1 = mult/div busy, 2 = mult/div finishing
   int          m_st = 0;
   int          m_left = 0;
   bit          m_live = 0;
   logic [31:0] m_stall = '0;

   // {pc_en, ifid_en, idex_en, ifid_flush, idex_flush, exmem_flush, md_busy, md_done}
   function automatic logic [7:0] exp_out();
      logic lu;
      if (!reset || !m_live) return 8'b0000_0000;
      if (m_st == 1)         return 8'b0000_0110;
      if (m_st == 2)         return 8'b1110_0001;
      lu = ex_memread && (ex_rt != 5'd0) && (ex_rt == id_rs || ex_rt == id_rt);
      if (lu && !ex_md_start) return 8'b0010_1000;
      if (id_branch_taken)    return 8'b1111_0000;
      return 8'b1110_0000;
   endfunction

   always @(posedge clk or negedge reset) begin
      logic [7:0] v;
      if (!reset) begin
         m_st <= 0; m_left <= 0; m_live <= 0; m_stall <= '0;
      end else begin
         v = exp_out();
         if (m_live && !v[7] && m_stall != 32'hFFFF_FFFF) m_stall <= m_stall + 32'd1;
         m_live <= 1;
         case (m_st)
            1: begin
               if (m_left == 1) m_st <= 2;
               m_left <= m_left - 1;
            end
            2: m_st <= 0;
            default: if (ex_md_start) begin m_st <= 1; m_left <= MDL; end
         endcase
      end
   end

   always @(negedge clk) begin
      logic [7:0]    e, a;
      logic [CW-1:0] es;
      e = exp_out();
      a = {pc_en, ifid_en, idex_en, ifid_flush, idex_flush, exmem_flush, md_busy, md_done};
      vectors++;
      if (a !== e) begin
         miscompares++;
         $display("FAIL ctrl @%0t: got %b want %b", $time, a, e);
      end
`ifdef STALL_CNT_EN
      es = m_stall;
`else
      es = '0;
`endif
      vectors++;
      if (stall_cycles !== es) begin
         miscompares++;
         $display("FAIL stall_cycles @%0t: got %0d want %0d", $time, stall_cycles, es);
      end
   end

   task automatic lit(string nm, logic act, logic exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %b want %b", nm, act, exp);
      end
   endtask

   task automatic lit32(string nm, logic [31:0] act, logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   task automatic set_in(logic mr, logic [4:0] xrt, logic [4:0] rs, logic [4:0] rt,
                         logic br, logic ms);
      ex_memread = mr; ex_rt = xrt; id_rs = rs; id_rt = rt;
      id_branch_taken = br; ex_md_start = ms;
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic at_neg();
      @(negedge clk); #1;
   endtask

   initial begin
      reset = 1'b0;
      set_in(0, 0, 0, 0, 0, 0);
      tick(); tick();
      reset = 1'b1;
      tick();
      // T1 release
      at_neg();
      lit("t1_pc_en", pc_en, 1'b1);
      lit("t1_ifid_en", ifid_en, 1'b1);
      lit("t1_idex_en", idex_en, 1'b1);
      tick();
      // T2 load-use, then the bubble, then r0 destination
      set_in(1, 5'd8, 5'd8, 5'd3, 0, 0); at_neg();
      lit("t2_pc_en", pc_en, 1'b0);
      lit("t2_ifid_en", ifid_en, 1'b0);
      lit("t2_idex_flush", idex_flush, 1'b1);
      tick();
      set_in(0, 5'd0, 5'd0, 5'd0, 0, 0); at_neg();
      lit("t2_after_pc_en", pc_en, 1'b1);
      tick();
      set_in(1, 5'd0, 5'd0, 5'd0, 0, 0); at_neg();
      lit("t2_r0_pc_en", pc_en, 1'b1);
      lit("t2_r0_idex_flush", idex_flush, 1'b0);
      tick();
      // T4 mult/div with MD_LAT=4
      set_in(0, 5'd0, 5'd0, 5'd0, 0, 1); at_neg();
      lit("t4_start_pc_en", pc_en, 1'b1);
      lit("t4_start_busy", md_busy, 1'b0);
      tick();
      for (int i = 0; i < MDL; i++) begin
         at_neg();
         lit("t4_busy", md_busy, 1'b1);
         lit("t4_exmem_flush", exmem_flush, 1'b1);
         lit("t4_busy_pc_en", pc_en, 1'b0);
         tick();
      end
      at_neg();
      lit("t4_done", md_done, 1'b1);
      lit("t4_done_pc_en", pc_en, 1'b1);
      lit("t4_done_busy", md_busy, 1'b0);
      lit32("t6_stall_cycles", stall_cycles, T6_EXP);
      tick();
      set_in(0, 5'd0, 5'd0, 5'd0, 0, 0); at_neg();
      lit("t4_after_busy", md_busy, 1'b0);
      lit("t4_after_done", md_done, 1'b0);
      tick();
      // T3 branch with and without load-use
      set_in(1, 5'd8, 5'd5, 5'd8, 1, 0); at_neg();
      lit("t3_both_ifid_flush", ifid_flush, 1'b0);
      lit("t3_both_pc_en", pc_en, 1'b0);
      tick();
      set_in(0, 5'd8, 5'd5, 5'd8, 1, 0); at_neg();
      lit("t3_br_ifid_flush", ifid_flush, 1'b1);
      lit("t3_br_pc_en", pc_en, 1'b1);
      tick();
      // T5 reset on the second busy cycle
      set_in(0, 5'd0, 5'd0, 5'd0, 0, 1);
      tick(); tick();
      reset = 1'b0; at_neg();
      lit("t5_busy_in_reset", md_busy, 1'b0);
      lit("t5_pc_en_in_reset", pc_en, 1'b0);
      tick();
      set_in(0, 5'd0, 5'd0, 5'd0, 0, 0);
      reset = 1'b1;
      tick();
      for (int i = 0; i < 6; i++) begin
         at_neg();
         lit("t5_no_done", md_done, 1'b0);
         tick();
      end
      // Randomized phase
      for (int n = 0; n < 800; n++) begin
         logic ms;
         reset = ($urandom_range(0, 79) != 0);
         ms = (m_st == 1) ? 1'b1 : ($urandom_range(0, 9) == 0);
         set_in($urandom_range(0, 2) == 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), $urandom_range(0, 3) == 0, ms);
         tick();
      end
      reset = 1'b1;
      at_neg();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
